// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART receive and transmit paths.
//   uartState_t : FSM state encoding for the receiver
//   calcDiv()   : clk cycles per oversample tick, rounded to nearest
// Build option: UART_RX_PARITY_EN adds the PARITY state to the encoding.
package uart_pkg;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } uartState_t;
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } uartState_t;
`endif

    // Rounded divide so the bit period error stays within half a clk cycle
    // per tick; never returns 0 so the divider always makes progress.
    function automatic int unsigned calcDiv(input int unsigned clkHz,
                                            input int unsigned baud,
                                            input int unsigned oversample);
        logic [63:0] den;
        logic [63:0] quo;
        den = 64'(baud) * 64'(oversample);
        if (den == 64'd0) begin
            return 1;
        end
        quo = (64'(clkHz) + (den >> 1)) / den;
        if (quo == 64'd0) begin
            quo = 64'd1;
        end
        return quo[31:0];
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if
// Read-side bundle of the UART receiver.
//   rd_en      : consumer pops the head word (ignored while rd_valid=0)
//   rd_data    : head word, first-word-fall-through, 0 while empty
//   rd_valid   : buffer non-empty
//   frame_err  : one-cycle pulse, stop bit sampled low
//   parity_err : one-cycle pulse, parity mismatch
//   overrun    : one-cycle pulse, word dropped because the buffer was full
// Modports: master = receiver side, slave = consumer side.
interface uart_rx_fifo_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic                 rd_en;
    logic [DATA_BITS-1:0] rd_data;
    logic                 rd_valid;
    logic                 frame_err;
    logic                 parity_err;
    logic                 overrun;

    modport master (
        input  rd_en,
        output rd_data,
        output rd_valid,
        output frame_err,
        output parity_err,
        output overrun
    );

    modport slave (
        output rd_en,
        input  rd_data,
        input  rd_valid,
        input  frame_err,
        input  parity_err,
        input  overrun
    );
endinterface

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo
// Synchronous first-word-fall-through buffer, WIDTH x DEPTH.
//   clk, reset   : clock, asynchronous active-high reset
//   push_i       : write pushData_i (dropped with overrun_o if full and no pop)
//   pushData_i   : word to store
//   pop_i        : remove head word (ignored while empty)
//   popData_o    : head word, 0 while empty
//   valid_o      : buffer non-empty
//   overrun_o    : one-cycle pulse when a push was dropped
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] pushData_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] popData_o,
    output logic             valid_o,
    output logic             overrun_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overrun_q, overrun_d;
    logic             empty, full, doPush, doPop;

    assign empty  = (count_q == '0);
    assign full   = (count_q == CNT_W'(DEPTH));
    assign doPop  = pop_i && !empty;
    // A pop in the same cycle frees the slot, so a full buffer still accepts.
    assign doPush = push_i && (!full || doPop);

    // Pointers wrap naturally because DEPTH is a power of two; the count
    // tells full from empty when the pointers coincide.
    always_comb begin
        wrPtr_d   = wrPtr_q;
        rdPtr_d   = rdPtr_q;
        count_d   = count_q;
        overrun_d = push_i && !doPush;
        if (doPush) begin
            wrPtr_d = wrPtr_q + PTR_W'(1);
        end
        if (doPop) begin
            rdPtr_d = rdPtr_q + PTR_W'(1);
        end
        case ({doPush, doPop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            wrPtr_q   <= wrPtr_d;
            rdPtr_q   <= rdPtr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    // Storage needs no reset: the head output is masked while empty.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= pushData_i;
        end
    end

    assign popData_o = empty ? '0 : mem_q[rdPtr_q];
    assign valid_o   = !empty;
    assign overrun_o = overrun_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// Oversampling UART receiver feeding a small FWFT receive buffer.
//   clk   : system clock
//   reset : asynchronous active-high reset
//   rx    : serial line, idle high, asynchronous to clk
//   rdIf  : read/status bundle (uart_rx_fifo_if.master)
// Build option: UART_RX_PARITY_EN adds a parity bit after the data bits,
// sense chosen by PARITY_ODD (0 = even); without it parity_err is tied 0.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned FIFO_DEPTH = 4
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit          PARITY_ODD = 1'b0
`endif
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           rx,
    uart_rx_fifo_if.master rdIf
);
    localparam int unsigned DIV    = calcDiv(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int unsigned DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W  = $clog2(DATA_BITS);

    logic                 rxMeta_q, rxSync_q, rxPrev_q;
    uartState_t           state_q, state_d;
    logic [DIV_W-1:0]     divCnt_q, divCnt_d;
    logic                 tick;
    logic [TICK_W-1:0]    tickCnt_q, tickCnt_d;
    logic [BIT_W-1:0]     bitCnt_q, bitCnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 frameErr_q, frameErr_d;
    logic                 push;
    logic                 parityFailed;

`ifdef UART_RX_PARITY_EN
    logic parityBad_q, parityBad_d;
    logic parityErr_q, parityErr_d;
    logic expectedParity;

    assign expectedParity = (^shift_q) ^ PARITY_ODD;
    assign parityFailed   = parityBad_q;
`else
    assign parityFailed   = 1'b0;
`endif

    // Two-flop synchronizer plus a delayed copy for falling-edge detection;
    // all reset high so a held reset never looks like a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rxMeta_q <= 1'b1;
            rxSync_q <= 1'b1;
            rxPrev_q <= 1'b1;
        end else begin
            rxMeta_q <= rx;
            rxSync_q <= rxMeta_q;
            rxPrev_q <= rxSync_q;
        end
    end

    // The tick divider sits at 0 in IDLE so every frame starts phase-aligned
    // to its own start edge.
    assign tick = (state_q != IDLE) && (divCnt_q == DIV_W'(DIV - 1));

    always_comb begin
        divCnt_d = divCnt_q + DIV_W'(1);
        if ((state_q == IDLE) || tick) begin
            divCnt_d = '0;
        end
    end

    // Receiver state and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            divCnt_q   <= '0;
            tickCnt_q  <= '0;
            bitCnt_q   <= '0;
            shift_q    <= '0;
            frameErr_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            divCnt_q   <= divCnt_d;
            tickCnt_q  <= tickCnt_d;
            bitCnt_q   <= bitCnt_d;
            shift_q    <= shift_d;
            frameErr_q <= frameErr_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parityBad_q <= 1'b0;
            parityErr_q <= 1'b0;
        end else begin
            parityBad_q <= parityBad_d;
            parityErr_q <= parityErr_d;
        end
    end
`endif

    // Next-state logic. START samples at half a bit to find the bit centre;
    // from then on every OVERSAMPLE ticks lands on the next centre.
    always_comb begin
        state_d    = state_q;
        tickCnt_d  = tickCnt_q;
        bitCnt_d   = bitCnt_q;
        shift_d    = shift_q;
        frameErr_d = 1'b0;
        push       = 1'b0;
`ifdef UART_RX_PARITY_EN
        parityBad_d = parityBad_q;
        parityErr_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                tickCnt_d = '0;
                if (rxPrev_q && !rxSync_q) begin
                    state_d = START;
`ifdef UART_RX_PARITY_EN
                    parityBad_d = 1'b0;
`endif
                end
            end
            START: begin
                if (tick) begin
                    if (tickCnt_q == TICK_W'(OVERSAMPLE / 2 - 1)) begin
                        tickCnt_d = '0;
                        bitCnt_d  = '0;
                        // A line back high at mid start bit was a glitch.
                        state_d   = rxSync_q ? IDLE : DATA;
                    end else begin
                        tickCnt_d = tickCnt_q + TICK_W'(1);
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (tickCnt_q == TICK_W'(OVERSAMPLE - 1)) begin
                        tickCnt_d = '0;
                        // LSB arrives first, so shift in from the top.
                        shift_d   = {rxSync_q, shift_q[DATA_BITS-1:1]};
                        if (bitCnt_q == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            bitCnt_d = bitCnt_q + BIT_W'(1);
                        end
                    end else begin
                        tickCnt_d = tickCnt_q + TICK_W'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    if (tickCnt_q == TICK_W'(OVERSAMPLE - 1)) begin
                        tickCnt_d   = '0;
                        parityBad_d = rxSync_q ^ expectedParity;
                        parityErr_d = rxSync_q ^ expectedParity;
                        state_d     = STOP;
                    end else begin
                        tickCnt_d = tickCnt_q + TICK_W'(1);
                    end
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (tickCnt_q == TICK_W'(OVERSAMPLE - 1)) begin
                        tickCnt_d = '0;
                        // A frame that already flagged parity gets no second
                        // error pulse and is never stored.
                        if (rxSync_q) begin
                            push    = !parityFailed;
                            state_d = IDLE;
                        end else begin
                            frameErr_d = !parityFailed;
                            state_d    = BREAK;
                        end
                    end else begin
                        tickCnt_d = tickCnt_q + TICK_W'(1);
                    end
                end
            end
            BREAK: begin
                // Wait out a held-low line before hunting for a new start edge.
                tickCnt_d = '0;
                if (rxSync_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                tickCnt_d = '0;
            end
        endcase
    end

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) rxBuffer (
        .clk        (clk),
        .reset      (reset),
        .push_i     (push),
        .pushData_i (shift_q),
        .pop_i      (rdIf.rd_en),
        .popData_o  (rdIf.rd_data),
        .valid_o    (rdIf.rd_valid),
        .overrun_o  (rdIf.overrun)
    );

    assign rdIf.frame_err = frameErr_q;
`ifdef UART_RX_PARITY_EN
    assign rdIf.parity_err = parityErr_q;
`else
    assign rdIf.parity_err = 1'b0;
`endif

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
  CLK_HZ  50_000_000  clk frequency in Hz
  BAUD  9600  line rate in bit/s
  DATA_BITS  8  data bits per frame, legal 5..9
  OVERSAMPLE  16  sample ticks per bit, even, >=8
  FIFO_DEPTH  4  receive buffer words, power of 2, >=2
REQ-002 Ports SHALL be (name  direction  width  meaning):
  clk  in  1  system clock
  reset  in  1  reset, asynchronous, active-high
  rx  in  1  serial line, idle high, asynchronous to clk
  rd_en  in  1  pop head word when rd_valid=1
  rd_data  out  DATA_BITS  FIFO head word (first-word-fall-through)
  rd_valid  out  1  FIFO non-empty
  frame_err  out  1  one-cycle pulse, stop bit sampled 0
  parity_err  out  1  one-cycle pulse, parity mismatch (0 when parity compiled out)
  overrun  out  1  one-cycle pulse, word dropped because FIFO full

Function
REQ-003 rx SHALL pass through a 2-flop synchronizer before any use; all sampling uses the synchronized value.
REQ-004 A tick pulse SHALL be generated every DIV = round(CLK_HZ/(BAUD*OVERSAMPLE)) clk cycles (50 MHz/9600/16 -> 326); the divider free-runs only while the FSM is not IDLE and restarts at 0 on leaving IDLE.
REQ-005 FSM states SHALL be IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-006 IDLE -> START on synchronized rx 1->0 transition.
REQ-007 START SHALL sample rx at tick OVERSAMPLE/2; rx=1 -> IDLE (glitch reject, no output); rx=0 -> DATA with tick counter cleared.
REQ-008 DATA SHALL sample every OVERSAMPLE ticks thereafter (bit centre), LSB first, DATA_BITS bits, then -> PARITY if enabled, else -> STOP.
REQ-009 STOP SHALL sample at bit centre; rx=1 -> word pushed (unless parity error) and -> IDLE; rx=0 -> frame_err pulse, word discarded, -> BREAK.
REQ-010 BREAK SHALL hold until synchronized rx=1, then -> IDLE; no new frame is accepted from BREAK.
REQ-011 rd_valid SHALL assert on the clk edge after the stop-bit centre sample of an accepted word.
REQ-012 Push with FIFO full SHALL drop the new word, keep contents, pulse overrun; push and pop in the same cycle with FIFO full SHALL succeed (pop frees the slot).
REQ-013 rd_en with rd_valid=0 SHALL be ignored; pointers wrap modulo FIFO_DEPTH with a separate count to distinguish full/empty.
REQ-014 At most one error pulse per frame; error pulses never coincide with a push.

Reset
REQ-015 reset SHALL force FSM=IDLE, divider/bit counters=0, FIFO empty, rd_valid=0, rd_data=0, all error pulses 0, synchronizer flops=1.
REQ-016 reset asserted mid-frame SHALL abandon the frame; after release, reception resumes at the next falling edge of rx.

Configuration
REQ-017 Macro UART_RX_PARITY_EN defined: PARITY state present, one parity bit after data, parameter PARITY_ODD (default 0: even) selects sense, mismatch -> parity_err pulse, word discarded, FSM continues to STOP.
REQ-018 Macro undefined: PARITY state, PARITY_ODD and parity logic absent; parity_err tied 0; frame = start + DATA_BITS + stop.

Structure
REQ-019 Shared package uart_pkg SHALL hold the FSM state encoding and the DIV computation function; both reused by the transmitter.
REQ-020 Sub-module uart_sync_fifo (synchronous FWFT FIFO, DATA_BITS x FIFO_DEPTH, overrun flag) SHALL implement buffering; FSM and divider stay in uart_rx_fifo.

Verification
REQ-021 Defaults, send 8'h35 framed at 9600 -> rd_valid after ~9.5 bit times, rd_data=8'h35, no error pulses.
REQ-022 2 us low glitch on idle rx -> FSM returns to IDLE, rd_valid stays 0.
REQ-023 8'h41 with stop bit driven 0 for 3 bit times -> one frame_err pulse, FIFO empty, next 8'h42 received correctly.
REQ-024 Send 8'h41..8'h45 with rd_en=0 -> overrun pulse on 5th; reads return 41,42,43,44 then rd_valid=0.
REQ-025 UART_RX_PARITY_EN, even parity, 8'h07 with parity bit 0 -> parity_err pulse, FIFO unchanged.
REQ-026 reset pulse during bit 4 of a frame -> outputs at reset values; following 8'h30 received intact.
